// File: rtl/axi_rw_arbiter_pkg.sv
// axi_rw_arbiter_pkg: request/response encodings and arbiter state type
package axi_rw_arbiter_pkg;
   localparam int         SIZE_W      = 2;
   localparam logic       REQ_READ    = 1'b0;
   localparam logic       REQ_WRITE   = 1'b1;
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   typedef enum logic [1:0] {ARB_IDLE, ARB_IF, ARB_MEM, ARB_DRAIN} arb_state_t;
endpackage

// File: rtl/axi_rw_arbiter_if.sv
// axi_rw_arbiter_if: one valid/ready request channel; the requester side uses master,
// the responding side uses slave
interface axi_rw_arbiter_if #(
   parameter int ADDR_W = 64,
   parameter int DATA_W = 64
);
   import axi_rw_arbiter_pkg::*;
   logic              valid;
   logic [ADDR_W-1:0] addr;
   logic [SIZE_W-1:0] size;
   logic              req;
   logic [DATA_W-1:0] data_write;
   logic              ready;
   logic [DATA_W-1:0] data_read;
   logic [1:0]        resp;
   modport master (output valid, addr, size, req, data_write, input ready, data_read, resp);
   modport slave (input valid, addr, size, req, data_write, output ready, data_read, resp);
endinterface

// File: rtl/axi_rw_arbiter_wdog.sv
// arb_wdog: grant watchdog; o_expire rises once TIMEOUT_CYC-1 stalled cycles have
// accumulated since the last clear
module arb_wdog #(
   parameter int TIMEOUT_CYC = 256
) (
   input  logic clk,
   input  logic rst,
   input  logic i_clr,
   input  logic i_inc,
   output logic o_expire
);
   localparam int CW = $clog2(TIMEOUT_CYC);
   logic [CW-1:0] r_cnt;
   always_ff @(posedge clk)
      if (rst || i_clr) r_cnt <= '0;
      else if (i_inc) r_cnt <= r_cnt + 1'b1;
   assign o_expire = r_cnt == CW'(TIMEOUT_CYC - 1);
endmodule

// File: rtl/axi_rw_arbiter.sv
// axi_rw_arbiter: shares the bridge port between fetch and memory stage, mem > if, one transaction outstanding
module axi_rw_arbiter
  import axi_rw_arbiter_pkg::*;
#(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64,
  parameter int TIMEOUT_CYC = 256
) (
  input logic              clk,
  input logic              rst,
  axi_rw_arbiter_if.slave  if_bus,
  axi_rw_arbiter_if.slave  mem_bus,
  axi_rw_arbiter_if.master rw_bus
);
  arb_state_t        r_state, w_next;
  logic [ADDR_W-1:0] r_addr;
  logic [SIZE_W-1:0] r_size;
  logic              r_req;
  logic [DATA_W-1:0] r_wdata;
  logic              w_grant, w_xfer, w_to, w_if_done, w_mem_done;
  assign w_grant = r_state == ARB_IDLE && (mem_bus.valid || if_bus.valid);
  assign w_xfer  = r_state == ARB_IF || r_state == ARB_MEM;
`ifdef ARB_TIMEOUT_EN
  logic w_expire;
  arb_wdog #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_wdog (
    .clk      (clk),
    .rst      (rst),
    .i_clr    (w_grant),
    .i_inc    (w_xfer && !rw_bus.ready),
    .o_expire (w_expire)
  );
  assign w_to = w_xfer && !rw_bus.ready && w_expire;
`else
  assign w_to = 1'b0;
`endif
  always_ff @(posedge clk)
    if (rst) r_state <= ARB_IDLE;
    else r_state <= w_next;
  always_comb
    w_next = r_state == ARB_IDLE ? (mem_bus.valid ? ARB_MEM : if_bus.valid ? ARB_IF : ARB_IDLE) :
             rw_bus.ready ? ARB_IDLE : w_to ? ARB_DRAIN : r_state;
  always_ff @(posedge clk)
    if (rst) begin
      r_addr  <= '0;
      r_size  <= '0;
      r_req   <= 1'b0;
      r_wdata <= '0;
    end else if (w_grant) begin
      r_addr  <= mem_bus.valid ? mem_bus.addr : if_bus.addr;
      r_size  <= mem_bus.valid ? mem_bus.size : if_bus.size;
      r_req   <= mem_bus.valid ? mem_bus.req : if_bus.req;
      r_wdata <= mem_bus.valid ? mem_bus.data_write : if_bus.data_write;
    end
  assign rw_bus.valid      = r_state != ARB_IDLE;
  assign rw_bus.addr       = r_addr;
  assign rw_bus.size       = r_size;
  assign rw_bus.req        = r_req;
  assign rw_bus.data_write = r_wdata;
  assign w_if_done  = r_state == ARB_IF && rw_bus.ready;
  assign w_mem_done = r_state == ARB_MEM && rw_bus.ready;
  assign if_bus.ready      = r_state == ARB_IF && (rw_bus.ready || w_to);
  assign if_bus.data_read  = w_if_done ? rw_bus.data_read : '0;
  assign if_bus.resp       = w_if_done ? rw_bus.resp : (r_state == ARB_IF && w_to) ? RESP_SLVERR : RESP_OKAY;
  assign mem_bus.ready     = r_state == ARB_MEM && (rw_bus.ready || w_to);
  assign mem_bus.data_read = w_mem_done ? rw_bus.data_read : '0;
  assign mem_bus.resp      = w_mem_done ? rw_bus.resp : (r_state == ARB_MEM && w_to) ? RESP_SLVERR : RESP_OKAY;
endmodule
